diff_scan_seq: RTL and testbench

- Multi-cycle, parametrised first-differing-bit unit for the csRISC execute stage; successor to the single-cycle 32-bit combinational diff.
- XORs two WIDTH-bit operands, then scans CHUNK bits per cycle, LSB-first or MSB-first, with early termination.
- Returns the 1-based position of the first differing bit, or 0 if the operands are equal.
- Start/busy/done handshake to the ALU sequencer.

---
 rtl/diff_scan_seq_if.sv | 56 +++++
 rtl/diff_scan_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_diff_scan_seq.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/diff_scan_seq_if.sv
// ---------------------------------------------------------------------------
// diff_scan_seq_if
//   Bundle between the ALU sequencer (master) and the first-differing-bit
//   scan unit (slave).
//
//   Handshake: the master raises start for one cycle together with mode,
//   inp1 and inp2. The slave accepts it only while idle (busy low); a start
//   seen while busy is dropped and its operands are not latched. The slave
//   answers with a single-cycle done pulse. out/equal (and hamming when
//   built in) are valid from the done cycle and hold until the next done or
//   reset. A start raised in the done cycle is accepted immediately.
//
//   Signals:
//     start, mode, inp1, inp2   master -> slave request
//     busy, done, out, equal    slave -> master status and result
//     hamming                   slave -> master, only with DIFF_POPCOUNT_EN
//     state_dbg                 slave -> master, current FSM state (0 idle,
//                               1 scanning) for observation only
// ---------------------------------------------------------------------------
interface diff_scan_seq_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] out;
  logic             equal;
`ifdef DIFF_POPCOUNT_EN
  logic [OUT_W-1:0] hamming;
`endif
  logic             state_dbg;

`ifdef DIFF_POPCOUNT_EN
  modport master (
    output start, mode, inp1, inp2,
    input  busy, done, out, equal, hamming, state_dbg
  );
  modport slave (
    input  start, mode, inp1, inp2,
    output busy, done, out, equal, hamming, state_dbg
  );
`else
  modport master (
    output start, mode, inp1, inp2,
    input  busy, done, out, equal, state_dbg
  );
  modport slave (
    input  start, mode, inp1, inp2,
    output busy, done, out, equal, state_dbg
  );
`endif
endinterface

// File: rtl/diff_scan_seq.sv
// ---------------------------------------------------------------------------
// diff_scan_seq
//   Multi-cycle first-differing-bit unit. The operands are XORed when the
//   request is accepted; the XOR word is then scanned CHUNK bits per cycle,
//   from the LSB end (mode 0, lowest differing bit) or the MSB end (mode 1,
//   highest differing bit). The result is the 1-based index of the first
//   hit (bit i reports i+1), or 0 with equal=1 when the operands match.
//
//   Optional build macro: DIFF_POPCOUNT_EN
//     Adds the hamming output (popcount of the XOR word, accumulated chunk by
//     chunk). Early termination is off in this build: every operation walks
//     all WIDTH/CHUNK chunks; out still reports the first hit in scan order.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset; aborts a scan without a done pulse
//     bus   diff_scan_seq_if.slave: start/mode/inp1/inp2 in,
//           busy/done/out/equal[/hamming]/state_dbg out
//
//   Timing: start sampled at edge E0, busy high for k cycles (k = chunks
//   examined), done high for one cycle right after the last scan edge.
// ---------------------------------------------------------------------------
module diff_scan_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  diff_scan_seq_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BIT_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
      $error("diff_scan_seq: WIDTH must be a positive multiple of CHUNK");
    end
    if ((1 << OUT_W) <= WIDTH) begin : g_bad_out_w
      $error("diff_scan_seq: OUT_W too narrow to hold WIDTH");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q,   ptr_d;
  logic [WIDTH-1:0] x_q,     x_d;
  logic             mode_q,  mode_d;
  logic             done_q,  done_d;
  logic [OUT_W-1:0] out_q,   out_d;
  logic             equal_q, equal_d;
`ifdef DIFF_POPCOUNT_EN
  logic [OUT_W-1:0] acc_q,   acc_d;
  logic             found_q, found_d;
  logic [OUT_W-1:0] first_q, first_d;
  logic [OUT_W-1:0] ham_q,   ham_d;
`endif

  // -------------------------------------------------------------------------
  // Chunk examination: the slice under the pointer, its priority-encoded hit
  // and the resulting 1-based bit position.
  // -------------------------------------------------------------------------
  logic [CHUNK-1:0] chunk_v;
  logic             chunk_hit;
  logic [BIT_W-1:0] bit_idx;
  logic [OUT_W-1:0] hit_pos;
  logic             last_chunk;

  always_comb begin
    chunk_v   = x_q[ptr_q*CHUNK +: CHUNK];
    chunk_hit = |chunk_v;
    bit_idx   = '0;
    if (mode_q == 1'b0) begin
      // Walk downwards so the lowest set bit is the last one written.
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (chunk_v[i]) bit_idx = BIT_W'(i);
      end
    end else begin
      // Walk upwards so the highest set bit is the last one written.
      for (int i = 0; i < CHUNK; i++) begin
        if (chunk_v[i]) bit_idx = BIT_W'(i);
      end
    end
    hit_pos    = OUT_W'(ptr_q) * OUT_W'(CHUNK) + OUT_W'(bit_idx) + OUT_W'(1);
    last_chunk = mode_q ? (ptr_q == '0) : (ptr_q == LAST_PTR);
  end

`ifdef DIFF_POPCOUNT_EN
  logic [OUT_W-1:0] chunk_cnt;

  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_cnt = chunk_cnt + OUT_W'(chunk_v[i]);
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state and result logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    x_d     = x_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    out_d   = out_q;
    equal_d = equal_q;
`ifdef DIFF_POPCOUNT_EN
    acc_d   = acc_q;
    found_d = found_q;
    first_d = first_q;
    ham_d   = ham_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.inp1 ^ bus.inp2;
          mode_d  = bus.mode;
          ptr_d   = bus.mode ? LAST_PTR : '0;
          state_d = SCAN;
`ifdef DIFF_POPCOUNT_EN
          acc_d   = '0;
          found_d = 1'b0;
          first_d = '0;
`endif
        end
      end

      SCAN: begin
`ifdef DIFF_POPCOUNT_EN
        // Full walk: remember the first hit, keep counting until the end.
        acc_d = acc_q + chunk_cnt;
        if (!found_q && chunk_hit) begin
          found_d = 1'b1;
          first_d = hit_pos;
        end
        if (last_chunk) begin
          if (found_q)        out_d = first_q;
          else if (chunk_hit) out_d = hit_pos;
          else                out_d = '0;
          equal_d = !(found_q || chunk_hit);
          ham_d   = acc_q + chunk_cnt;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d = mode_q ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
        end
`else
        if (chunk_hit) begin
          out_d   = hit_pos;
          equal_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (last_chunk) begin
          out_d   = '0;
          equal_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d = mode_q ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      x_q     <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      equal_q <= 1'b0;
`ifdef DIFF_POPCOUNT_EN
      acc_q   <= '0;
      found_q <= 1'b0;
      first_q <= '0;
      ham_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      out_q   <= out_d;
      equal_q <= equal_d;
`ifdef DIFF_POPCOUNT_EN
      acc_q   <= acc_d;
      found_q <= found_d;
      first_q <= first_d;
      ham_q   <= ham_d;
`endif
    end
  end

  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = done_q;
  assign bus.out       = out_q;
  assign bus.equal     = equal_q;
  assign bus.state_dbg = state_q;
`ifdef DIFF_POPCOUNT_EN
  assign bus.hamming   = ham_q;
`endif

endmodule

// File: tb/tb_diff_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_diff_scan_seq
//   Self-checking bench for diff_scan_seq (WIDTH=32, CHUNK=8). Expected
//   results come from plan constants and from a bit-level reference model
//   that searches the XOR word directly.
// ---------------------------------------------------------------------------
module tb_diff_scan_seq;

  localparam int W      = 32;
  localparam int C      = 8;
  localparam int NCH    = W / C;
  localparam int OW     = $clog2(W + 1);
  localparam int BUDGET = NCH + 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  diff_scan_seq_if #(.WIDTH(W), .OUT_W(OW)) bus ();

  diff_scan_seq #(.WIDTH(W), .CHUNK(C), .OUT_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises start in the current cycle (cycle 0); returns in cycle 1 with the
  // request inputs scrambled so that un-latched operands would show up.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic m);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.inp1  = a;
    bus.inp2  = b;
    step();
    bus.start = 1'b0;
    bus.inp1  = $urandom;
    bus.inp2  = $urandom;
    bus.mode  = 1'($urandom_range(0, 1));
  endtask

  // Observes from the current cycle until done (bounded). Returns the cycle
  // number of done relative to cycle 1 = first call cycle, -1 on timeout.
  task automatic collect(output int done_cyc, output int busy_cyc,
                         output logic held_ok, output logic [OW-1:0] o,
                         output logic e, output logic [OW-1:0] h);
    logic [OW-1:0] o0;
    logic          e0;
    done_cyc = -1;
    busy_cyc = 0;
    held_ok  = 1'b1;
    o0 = bus.out;
    e0 = bus.equal;
    h  = '0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (bus.done === 1'b1) begin
        done_cyc = c;
        o = bus.out;
        e = bus.equal;
`ifdef DIFF_POPCOUNT_EN
        h = bus.hamming;
`endif
        return;
      end
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.out !== o0 || bus.equal !== e0) held_ok = 1'b0;
      step();
    end
    o = bus.out;
    e = bus.equal;
  endtask

  // -------------------------------------------------------- reference model
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic m, output logic [OW-1:0] o,
                                output logic e, output int k,
                                output logic [OW-1:0] h);
    logic [W-1:0] x;
    int pos;
    x   = a ^ b;
    pos = -1;
    if (m == 1'b0) begin
      for (int i = W - 1; i >= 0; i--) if (x[i]) pos = i;
    end else begin
      for (int i = 0; i < W; i++) if (x[i]) pos = i;
    end
    e = (pos < 0);
    o = e ? '0 : OW'(pos + 1);
`ifdef DIFF_POPCOUNT_EN
    k = NCH;
`else
    if (e)           k = NCH;
    else if (m == 0) k = pos / C + 1;
    else             k = NCH - pos / C;
`endif
    h = OW'($countones(x));
  endfunction

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.out !== '0) begin n_fail++; $display("FAIL reset_out: got %0d want 0", bus.out); end
    n_checks++; if (bus.equal !== 1'b0) begin n_fail++; $display("FAIL reset_equal: got %b want 0", bus.equal); end
    n_checks++; if (bus.state_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", bus.state_dbg); end
`ifdef DIFF_POPCOUNT_EN
    n_checks++; if (bus.hamming !== '0) begin n_fail++; $display("FAIL reset_hamming: got %0d want 0", bus.hamming); end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h01000000};
    logic [W-1:0] tb [6] = '{32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h80000001, 32'h80000001, 32'h0};
    logic         tm [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int           to [6] = '{5, 0, 0, 32, 1, 25};
    logic         te [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int           td [6] = '{2, 5, 5, 2, 2, 5};
    int dc, bc, want_dc;
    logic held, e;
    logic [OW-1:0] o, h;
    for (int i = 0; i < 6; i++) begin
`ifdef DIFF_POPCOUNT_EN
      want_dc = NCH + 1;
`else
      want_dc = td[i];
`endif
      drive_start(ta[i], tb[i], tm[i]);
      collect(dc, bc, held, o, e, h);
      n_checks++; if (dc !== want_dc) begin n_fail++; $display("FAIL dir%0d_done_cycle: got %0d want %0d", i, dc, want_dc); end
      n_checks++; if (bc !== want_dc - 1) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, want_dc - 1); end
      n_checks++; if (o !== OW'(to[i])) begin n_fail++; $display("FAIL dir%0d_out: got %0d want %0d", i, o, to[i]); end
      n_checks++; if (e !== te[i]) begin n_fail++; $display("FAIL dir%0d_equal: got %b want %b", i, e, te[i]); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, bus.busy); end
      step();
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width: got %b want 0", i, bus.done); end
      n_checks++; if (bus.out !== OW'(to[i])) begin n_fail++; $display("FAIL dir%0d_out_hold: got %0d want %0d", i, bus.out, to[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic m, held, e, e_exp;
    logic [OW-1:0] o, h, o_exp, h_exp;
    int dc, bc, k;
    drive_start(32'h01000000, 32'h0, 1'b0);
    collect(dc, bc, held, o, e, h);
    n_checks++; if (o !== OW'(25)) begin n_fail++; $display("FAIL b2b_first_out: got %0d want 25", o); end
`ifndef DIFF_POPCOUNT_EN
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 5", dc); end
`endif
    // Second request raised in the done cycle of the first.
    a = $urandom;
    b = a ^ (32'h1 << $urandom_range(0, W - 1));
    m = 1'($urandom_range(0, 1));
    model(a, b, m, o_exp, e_exp, k, h_exp);
    drive_start(a, b, m);
    collect(dc, bc, held, o, e, h);
    n_checks++; if (dc !== k + 1) begin n_fail++; $display("FAIL b2b_second_done: got %0d want %0d", dc, k + 1); end
    n_checks++; if (o !== o_exp) begin n_fail++; $display("FAIL b2b_second_out: got %0d want %0d", o, o_exp); end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL b2b_first_held: got %b want 1", held); end
    step();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_start_during_scan();
    int dc, bc;
    logic held, e;
    logic [OW-1:0] o, h;
    drive_start(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);   // cycle 1
    step();                                         // cycle 2
    bus.start = 1'b1;
    bus.inp1  = 32'h0;
    bus.inp2  = 32'h1;
    bus.mode  = 1'b0;
    step();                                         // cycle 3
    bus.start = 1'b0;
    collect(dc, bc, held, o, e, h);
    n_checks++; if (dc + 2 !== 5) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 5", dc + 2); end
    n_checks++; if (o !== '0) begin n_fail++; $display("FAIL ignore_out: got %0d want 0", o); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL ignore_equal: got %b want 1", e); end
    step();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_scan();
    int dc, bc, seen;
    logic held, e;
    logic [OW-1:0] o, h;
    drive_start(32'h0, 32'h10, 1'b0);
    collect(dc, bc, held, o, e, h);                 // leaves out = 5
    step();
    drive_start(32'h12345678, 32'h12345678, 1'b1);   // cycle 1
    step();                                          // cycle 2
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.inp1  = 32'h0;
    bus.inp2  = 32'h4;
    step();                                          // cycle 3
    rst       = 1'b0;
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.out !== '0) begin n_fail++; $display("FAIL rstmid_out: got %0d want 0", bus.out); end
    n_checks++; if (bus.equal !== 1'b0) begin n_fail++; $display("FAIL rstmid_equal: got %b want 0", bus.equal); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
      step();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", seen); end
    // rst and start together while idle: the request is dropped.
    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_busy: got %b want 0", bus.busy); end
    step();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_start_done: got %b want 0", bus.done); end
  endtask

`ifdef DIFF_POPCOUNT_EN
  task automatic test_popcount();
    int dc, bc;
    logic held, e;
    logic [OW-1:0] o, h;
    drive_start(32'hFFFF0000, 32'h000000FF, 1'b0);
    collect(dc, bc, held, o, e, h);
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL pop_done_cycle: got %0d want 5", dc); end
    n_checks++; if (o !== OW'(1)) begin n_fail++; $display("FAIL pop_out: got %0d want 1", o); end
    n_checks++; if (h !== OW'(24)) begin n_fail++; $display("FAIL pop_hamming: got %0d want 24", h); end
    step();
    step();
    n_checks++; if (bus.hamming !== OW'(24)) begin n_fail++; $display("FAIL pop_hamming_hold: got %0d want 24", bus.hamming); end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] a, b, one;
    logic m, held, e, e_exp;
    logic [OW-1:0] o, h, o_exp, h_exp;
    int dc, bc, k;
    one = 1;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (one << $urandom_range(0, W - 1));
        2:       b = $urandom;
        default: b = a ^ (one << $urandom_range(0, W - 1)) ^ (one << $urandom_range(0, W - 1));
      endcase
      m = 1'($urandom_range(0, 1));
      model(a, b, m, o_exp, e_exp, k, h_exp);
      drive_start(a, b, m);
      collect(dc, bc, held, o, e, h);
      n_checks++; if (dc !== k + 1) begin n_fail++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", n, dc, k + 1); end
      n_checks++; if (bc !== k) begin n_fail++; $display("FAIL rand%0d_busy_cycles: got %0d want %0d", n, bc, k); end
      n_checks++; if (o !== o_exp) begin n_fail++; $display("FAIL rand%0d_out: got %0d want %0d", n, o, o_exp); end
      n_checks++; if (e !== e_exp) begin n_fail++; $display("FAIL rand%0d_equal: got %b want %b", n, e, e_exp); end
      n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL rand%0d_result_hold: got %b want 1", n, held); end
`ifdef DIFF_POPCOUNT_EN
      n_checks++; if (h !== h_exp) begin n_fail++; $display("FAIL rand%0d_hamming: got %0d want %0d", n, h, h_exp); end
`endif
      if ($urandom_range(0, 1) == 1) begin
        step();
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rand%0d_done_width: got %b want 0", n, bus.done); end
      end
    end
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.inp1  = '0;
    bus.inp2  = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    step();
    test_start_during_scan();
    step();
    test_reset_mid_scan();
`ifdef DIFF_POPCOUNT_EN
    test_popcount();
    step();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
